// File: rtl/running_min_max_tracker_pkg.sv
// Shared types and constants for the running min/max tracker.
// The index outputs are enabled by the MIN_MAX_INDEX_EN macro in the top module.
package running_min_max_tracker_pkg;

  localparam int SAMPLE_W       = 4;
  localparam int WINDOW_LEN_MAX = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Clamp a requested window length into the supported 1..WINDOW_LEN_MAX range.
  function automatic int clamp_window_len(input int len);
    if (len < 1) return 1;
    if (len > WINDOW_LEN_MAX) return WINDOW_LEN_MAX;
    return len;
  endfunction

endpackage

// File: rtl/running_min_max_tracker_compare_unit.sv
// Combinational magnitude comparison of one sample against the running extremes.
// Ties report no update so the first occurrence of an extreme is kept.
module min_max_compare_unit
  import running_min_max_tracker_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] cur_min,
  input  logic [SAMPLE_W-1:0] cur_max,
  output logic                take_min,
  output logic                take_max
);

  assign take_min = (sample < cur_min);
  assign take_max = (sample > cur_max);

endmodule

// File: rtl/running_min_max_tracker.sv
// Tracks min, max and count of the samples accepted over a WINDOW_LEN-sample window.
// Define MIN_MAX_INDEX_EN to add Min_Index_Out/Max_Index_Out (position of each extreme).
//
// Handshake: a sample is accepted on a rising edge where Data_Valid_In and
// Data_Ready_Out are both high; Data_Ready_Out is high only while collecting and
// does not depend on Data_Valid_In.
module running_min_max_tracker
  import running_min_max_tracker_pkg::*;
#(
  parameter int WINDOW_LEN = 8
) (
  input  logic                Clock_In,
  input  logic                Reset_N_In,
  input  logic                Start_In,
  input  logic [SAMPLE_W-1:0] Data_In,
  input  logic                Data_Valid_In,
  output logic                Data_Ready_Out,
  output logic [SAMPLE_W-1:0] Min_Out,
  output logic [SAMPLE_W-1:0] Max_Out,
  output logic [SAMPLE_W-1:0] Count_Out,
  output logic                Busy_Out,
  output logic                Done_Out
`ifdef MIN_MAX_INDEX_EN
  ,
  output logic [SAMPLE_W-1:0] Min_Index_Out,
  output logic [SAMPLE_W-1:0] Max_Index_Out
`endif
);

  localparam int                  LEN  = clamp_window_len(WINDOW_LEN);
  localparam logic [SAMPLE_W:0]   LAST = LEN[SAMPLE_W:0];

  state_t              state, state_next;
  logic [SAMPLE_W-1:0] min_q, min_next;
  logic [SAMPLE_W-1:0] max_q, max_next;
  logic [SAMPLE_W-1:0] count_q, count_next;
  logic [SAMPLE_W:0]   count_inc;
  logic                accept;
  logic                first_sample;
  logic                take_min, take_max;
`ifdef MIN_MAX_INDEX_EN
  logic [SAMPLE_W-1:0] min_idx_q, min_idx_next;
  logic [SAMPLE_W-1:0] max_idx_q, max_idx_next;
`endif

  assign Data_Ready_Out = (state == COLLECT);
  assign Busy_Out       = (state == COLLECT);
  assign Done_Out       = (state == DONE);
  assign Min_Out        = min_q;
  assign Max_Out        = max_q;
  assign Count_Out      = count_q;
`ifdef MIN_MAX_INDEX_EN
  assign Min_Index_Out  = min_idx_q;
  assign Max_Index_Out  = max_idx_q;
`endif

  assign accept       = Data_Valid_In & Data_Ready_Out;
  assign first_sample = (count_q == '0);
  assign count_inc    = {1'b0, count_q} + 1'b1;

  min_max_compare_unit u_compare (
    .sample   (Data_In),
    .cur_min  (min_q),
    .cur_max  (max_q),
    .take_min (take_min),
    .take_max (take_max)
  );

  always_comb begin
    state_next   = state;
    min_next     = min_q;
    max_next     = max_q;
    count_next   = count_q;
`ifdef MIN_MAX_INDEX_EN
    min_idx_next = min_idx_q;
    max_idx_next = max_idx_q;
`endif
    unique case (state)
      IDLE: begin
        if (Start_In) begin
          state_next = COLLECT;
          count_next = '0;
        end
      end
      COLLECT: begin
        if (accept) begin
          count_next = count_inc[SAMPLE_W-1:0];
          // The first sample of a window overwrites whatever the last window left.
          if (first_sample || take_min) begin
            min_next = Data_In;
`ifdef MIN_MAX_INDEX_EN
            min_idx_next = count_q;
`endif
          end
          if (first_sample || take_max) begin
            max_next = Data_In;
`ifdef MIN_MAX_INDEX_EN
            max_idx_next = count_q;
`endif
          end
          if (count_inc == LAST) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state     <= IDLE;
      min_q     <= '0;
      max_q     <= '0;
      count_q   <= '0;
`ifdef MIN_MAX_INDEX_EN
      min_idx_q <= '0;
      max_idx_q <= '0;
`endif
    end else begin
      state     <= state_next;
      min_q     <= min_next;
      max_q     <= max_next;
      count_q   <= count_next;
`ifdef MIN_MAX_INDEX_EN
      min_idx_q <= min_idx_next;
      max_idx_q <= max_idx_next;
`endif
    end
  end

endmodule

// File: tb/tb_running_min_max_tracker.sv
// Bench for running_min_max_tracker: two instances (WINDOW_LEN 4 and 1) driven by
// directed and random stimulus, checked cycle by cycle against a window-list model.
module tb_running_min_max_tracker;

  localparam int W = 23;

  logic       clk;
  logic       rst_n;
  logic       start0, valid0, start1, valid1;
  logic [3:0] data0, data1;
  logic       rdy0, busy0, done0, rdy1, busy1, done1;
  logic [3:0] mn0, mx0, cnt0, mn1, mx1, cnt1;
  logic [W-1:0] act0, act1;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int vectors;
  int miscompares;

`ifdef MIN_MAX_INDEX_EN
  logic [3:0] mni0, mxi0, mni1, mxi1;
`endif

  running_min_max_tracker #(.WINDOW_LEN(4)) dut_w4 (
    .Clock_In       (clk),
    .Reset_N_In     (rst_n),
    .Start_In       (start0),
    .Data_In        (data0),
    .Data_Valid_In  (valid0),
    .Data_Ready_Out (rdy0),
    .Min_Out        (mn0),
    .Max_Out        (mx0),
    .Count_Out      (cnt0),
    .Busy_Out       (busy0),
    .Done_Out       (done0)
`ifdef MIN_MAX_INDEX_EN
    ,
    .Min_Index_Out  (mni0),
    .Max_Index_Out  (mxi0)
`endif
  );

  running_min_max_tracker #(.WINDOW_LEN(1)) dut_w1 (
    .Clock_In       (clk),
    .Reset_N_In     (rst_n),
    .Start_In       (start1),
    .Data_In        (data1),
    .Data_Valid_In  (valid1),
    .Data_Ready_Out (rdy1),
    .Min_Out        (mn1),
    .Max_Out        (mx1),
    .Count_Out      (cnt1),
    .Busy_Out       (busy1),
    .Done_Out       (done1)
`ifdef MIN_MAX_INDEX_EN
    ,
    .Min_Index_Out  (mni1),
    .Max_Index_Out  (mxi1)
`endif
  );

`ifdef MIN_MAX_INDEX_EN
  assign act0 = {rdy0, busy0, done0, mn0, mx0, cnt0, mni0, mxi0};
  assign act1 = {rdy1, busy1, done1, mn1, mx1, cnt1, mni1, mxi1};
`else
  assign act0 = {rdy0, busy0, done0, mn0, mx0, cnt0, 8'h00};
  assign act1 = {rdy1, busy1, done1, mn1, mx1, cnt1, 8'h00};
`endif

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each window is kept as the list of accepted samples; the extremes and their
  // first positions are recomputed from that list after every accept.
  int win_len[2] = '{4, 1};
  bit m_in_win[2];
  bit m_done[2];
  int m_n[2];
  int m_samp[2][16];
  int m_mn[2], m_mx[2], m_mni[2], m_mxi[2];

  function automatic void model_reset(input int k);
    m_in_win[k] = 0;
    m_done[k]   = 0;
    m_n[k]      = 0;
    m_mn[k]     = 0;
    m_mx[k]     = 0;
    m_mni[k]    = 0;
    m_mxi[k]    = 0;
  endfunction

  function automatic void model_step(input int k, input bit st, input bit vl, input int d);
    if (m_done[k]) begin
      m_done[k] = 0;
    end else if (!m_in_win[k]) begin
      if (st) begin
        m_in_win[k] = 1;
        m_n[k]      = 0;
      end
    end else if (vl) begin
      m_samp[k][m_n[k]] = d;
      m_n[k]++;
      m_mn[k]  = m_samp[k][0];
      m_mx[k]  = m_samp[k][0];
      m_mni[k] = 0;
      m_mxi[k] = 0;
      for (int i = 1; i < m_n[k]; i++) begin
        if (m_samp[k][i] < m_mn[k]) begin m_mn[k] = m_samp[k][i]; m_mni[k] = i; end
        if (m_samp[k][i] > m_mx[k]) begin m_mx[k] = m_samp[k][i]; m_mxi[k] = i; end
      end
      if (m_n[k] == win_len[k]) begin
        m_in_win[k] = 0;
        m_done[k]   = 1;
      end
    end
  endfunction

  function automatic logic [W-1:0] model_exp(input int k);
    logic [3:0] mni, mxi;
`ifdef MIN_MAX_INDEX_EN
    mni = 4'(m_mni[k]);
    mxi = 4'(m_mxi[k]);
`else
    mni = 4'h0;
    mxi = 4'h0;
`endif
    return {m_in_win[k], m_in_win[k], m_done[k], 4'(m_mn[k]), 4'(m_mx[k]), 4'(m_n[k]), mni, mxi};
  endfunction

  // ---------------- scoreboard ----------------
  function automatic void check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s @%0t: got {rdy,busy,done,min,max,cnt,mini,maxi}=%h expected %h",
               name, $time, act, exp_v);
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) check_vec("w4_cycle", act0, exp_q0.pop_front());
      if (exp_q1.size() > 0) check_vec("w1_cycle", act1, exp_q1.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit s0, input bit v0, input logic [3:0] d0,
                       input bit s1, input bit v1, input logic [3:0] d1);
    @(negedge clk);
    start0 = s0; valid0 = v0; data0 = d0;
    start1 = s1; valid1 = v1; data1 = d1;
    model_step(0, s0, v0, int'(d0));
    model_step(1, s1, v1, int'(d1));
    exp_q0.push_back(model_exp(0));
    exp_q1.push_back(model_exp(1));
  endtask

  task automatic drive0(input bit s, input bit v, input logic [3:0] d);
    drive(s, v, d, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic drive1(input bit s, input bit v, input logic [3:0] d);
    drive(1'b0, 1'b0, 4'h0, s, v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic window0(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    drive0(1'b1, 1'b0, 4'h0);
    drive0(1'b0, 1'b1, a);
    drive0(1'b0, 1'b1, b);
    drive0(1'b0, 1'b1, c);
    drive0(1'b0, 1'b1, d);
  endtask

  // Asserts reset away from any clock edge and checks the outputs clear at once.
  task automatic reset_mid;
    @(negedge clk);
    #2;
    start0 = 0; valid0 = 0; data0 = 0;
    start1 = 0; valid1 = 0; data1 = 0;
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    check_vec("w4_async_reset", act0, model_exp(0));
    check_vec("w1_async_reset", act1, model_exp(1));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    start0 = 0; valid0 = 0; data0 = 0;
    start1 = 0; valid1 = 0; data1 = 0;
    model_reset(0);
    model_reset(1);
    #2;
    check_vec("w4_reset_state", act0, model_exp(0));
    check_vec("w1_reset_state", act1, model_exp(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic window, with a Start during the DONE cycle that must be ignored.
    window0(4'd5, 4'd2, 4'd9, 4'd7);
    drive0(1'b1, 1'b1, 4'd3);
    idle(2);

    // All-equal window: ties keep the first position.
    window0(4'd6, 4'd6, 4'd6, 4'd6);
    idle(2);

    // Gap in valid, extremes 0 and F.
    drive0(1'b1, 1'b0, 4'h0);
    drive0(1'b0, 1'b1, 4'h3);
    drive0(1'b0, 1'b0, 4'hA);
    drive0(1'b0, 1'b1, 4'hF);
    drive0(1'b0, 1'b1, 4'h0);
    drive0(1'b0, 1'b1, 4'h8);
    idle(2);

    // Reset after two accepts, then a clean window.
    drive0(1'b1, 1'b0, 4'h0);
    drive0(1'b0, 1'b1, 4'd5);
    drive0(1'b0, 1'b1, 4'd9);
    reset_mid();
    idle(1);
    window0(4'd4, 4'd1, 4'd12, 4'd1);
    idle(1);

    // Valid in IDLE without Start, and Start re-pulsed during COLLECT.
    drive0(1'b0, 1'b1, 4'd1);
    drive0(1'b0, 1'b1, 4'd14);
    drive0(1'b1, 1'b0, 4'h0);
    drive0(1'b0, 1'b1, 4'd7);
    drive0(1'b1, 1'b1, 4'd3);
    drive0(1'b1, 1'b0, 4'd0);
    drive0(1'b0, 1'b1, 4'd11);
    drive0(1'b0, 1'b1, 4'd9);
    idle(2);

    // Single-sample windows.
    drive1(1'b1, 1'b0, 4'h0);
    drive1(1'b0, 1'b1, 4'hA);
    idle(3);
    drive1(1'b1, 1'b1, 4'h2);
    drive1(1'b0, 1'b1, 4'h0);
    drive1(1'b1, 1'b1, 4'h5);
    idle(2);

    // Random traffic on both instances, with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) reset_mid();
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)));
    end
    idle(2);

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0", exp_q0.size(), exp_q1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
